hilo_mdu_seq: RTL and testbench
===============================

# hilo_mdu_seq

Multi-cycle multiply/divide sequencer that owns every HI/LO write for MULT, MULTU, DIV and DIVU. The EXU issues one request per operation. The block runs a registered multiplier or a 32-step restoring divider, holds the pipeline through `stall` while busy, and returns one registered HI/LO write pulse. It sits beside the EXU ALU and drives the HI/LO register file write ports (`wHiData`/`whi`, `wLoData`/`wlo`).

## Interface
- `MUL_LATENCY`, default 2: number of cycles spent in state MUL (≥1).
- `clk`  input  1  sole clock; all state updates on its rising edge.
- `rst`  input  1  asynchronous, active-low reset (asserted at 0).
- `req_valid`  input  1  request present; upstream holds it until accepted.
- `req_op`  input  2  00 MULT, 01 MULTU, 10 DIV, 11 DIVU.
- `req_a`  input  32  operand A (rs / dividend).
- `req_b`  input  32  operand B (rt / divisor).
- `req_ready`  output  1  high only in IDLE.
- `flush`  input  1  synchronous cancel of the in-flight operation.
- `mf_req`  input  1  EXU holds MFHI/MFLO/MTHI/MTLO needing HI/LO.
- `stall`  output  1  `busy | (mf_req & busy)`; freezes the IDU→EXU pipeline register.
- `busy`  output  1  state ≠ IDLE.
- `res_valid`  output  1  one-cycle completion pulse.
- `wHiData`, `wLoData`  output  32 each  result words.
- `whi`, `wlo`  output  1 each  HI/LO write enables.

## Operation
- States: IDLE, MUL, DIV, DONE.
- Accept: `req_valid & req_ready & ~flush` at a rising edge. Operands, op and signedness are latched.
- IDLE→MUL for ops 00 and 01. A 64-bit product is computed on latched operands (signed for 00, unsigned for 01). The state stays in MUL for `MUL_LATENCY` cycles, then →DONE.
- IDLE→DIV for ops 10 and 11 with b≠0:
  - Magnitudes are taken (signed op only). 32 iterations run, one quotient bit per cycle, using a 33-bit partial remainder. Then →DONE.
  - At DIV exit: quotient sign is a[31]^b[31], remainder sign is a[31] (truncating division). Signed results are negated accordingly.
- DIV/DIVU with b=0: IDLE→DONE directly. In DONE, `res_valid`=1 and `whi`=`wlo`=0; HI/LO are not updated. Data outputs are LO=0xFFFFFFFF, HI=a.
- DONE: `res_valid`=1. `whi`=`wlo`=1 except for divide-by-zero. Data is valid. Next edge →IDLE.
- Overflow: 0x80000000 / 0xFFFFFFFF (signed) gives LO=0x80000000, HI=0. The result wraps and no trap is raised.
- `flush` (any state): next edge →IDLE. While `flush`=1, `res_valid`/`whi`/`wlo` are gated to 0 combinationally.
- `flush` with `req_valid` in IDLE: flush wins, nothing is accepted.
- `mf_req` in IDLE produces no stall. HI/LO access then proceeds in the EXU.
- Reset (`rst`=0, at any time, including mid-divide): state IDLE, all counters and datapath registers 0.
  - Output values during and after reset: `res_valid`/`whi`/`wlo`/`busy`/`stall`=0, `wHiData`/`wLoData`=0, `req_ready`=1.
  - The partial operation is discarded and no write is issued.

## Timing
- Accept at edge E0. MUL occupies cycles 1..`MUL_LATENCY`. `res_valid` is high in cycle `MUL_LATENCY`+1 (cycle 3 by default). IDLE is reached in cycle `MUL_LATENCY`+2.
- DIV occupies cycles 1..32, with `res_valid` in cycle 33. IDLE is reached in cycle 34.
- Divide-by-zero: `res_valid` in cycle 1.
- `req_ready` is 0 from cycle 1 through DONE. Back-to-back issue is therefore possible at the earliest in the first IDLE cycle after DONE.
- `busy`/`stall` go high in cycle 1 and drop in the IDLE cycle after DONE.
- All data and enable outputs are registered, except the `flush` gating.

## Test plan
- MULTU 0xFFFFFFFF×0xFFFFFFFF → cycle 3: HI=0xFFFFFFFE, LO=0x00000001, `whi`=`wlo`=1, `res_valid` exactly 1 cycle.
- MULT 0xFFFFFFFF×0xFFFFFFFF → HI=0, LO=1. MULT 0x7FFFFFFF×2 → HI=0, LO=0xFFFFFFFE.
- DIV −7/2 → cycle 33: LO=0xFFFFFFFD, HI=0xFFFFFFFF. DIVU 100/7 → LO=14, HI=2. DIV 0x80000000/−1 → LO=0x80000000, HI=0. Check `busy` for 33 cycles and `req_ready`=0 throughout.
- DIVU 5/0 → `res_valid`=1 in cycle 1 with `whi`=`wlo`=0. No write occurs and `busy` ends after one cycle.
- DIV started, `flush` at cycle 10 → IDLE next edge, no `res_valid`. A new MULTU 3×4 is accepted and returns LO=12. Repeat with `flush` in the DONE cycle: the write is suppressed.
- `rst` pulsed low at cycle 20 of a DIV → all outputs 0 immediately and `req_ready`=1 after release. Also check: `mf_req` during MUL holds `stall`=1 until the IDLE cycle, and a `req_valid` held while busy is accepted only in IDLE.

Source files
------------

// File: rtl/hilo_mdu_seq.sv
// rtl/hilo_mdu_seq.sv - multi-cycle MULT/MULTU/DIV/DIVU sequencer driving the HI/LO write ports
module hilo_mdu_seq #(
  parameter int unsigned MUL_LATENCY = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  input  logic [1:0]  req_op,
  input  logic [31:0] req_a,
  input  logic [31:0] req_b,
  output logic        req_ready,
  input  logic        flush,
  input  logic        mf_req,
  output logic        stall,
  output logic        busy,
  output logic        res_valid,
  output logic [31:0] wHiData,
  output logic [31:0] wLoData,
  output logic        whi,
  output logic        wlo
);

  typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_DONE} state_t;

  state_t      state_q, state_d;
  logic [31:0] cnt_q, cnt_d;
  logic [31:0] a_q, a_d;
  logic [31:0] b_q, b_d;
  logic [31:0] rem_q, rem_d;
  logic        sgn_q, sgn_d;
  logic        qneg_q, qneg_d;
  logic        rneg_q, rneg_d;
  logic [31:0] hi_q, hi_d;
  logic [31:0] lo_q, lo_d;
  logic        rv_q, rv_d;
  logic        we_q, we_d;

  logic [63:0] mul_a, mul_b, prod;
  logic [32:0] rem_sh, rem_diff;
  logic [31:0] q_next, r_next;
  logic        op_signed;

  // Sign/zero extension to 64 bits makes the low 64 product bits exact for both signednesses.
  assign mul_a = {{32{sgn_q & a_q[31]}}, a_q};
  assign mul_b = {{32{sgn_q & b_q[31]}}, b_q};
  assign prod  = mul_a * mul_b;

  // One restoring step: a_q shifts dividend bits out and quotient bits in.
  assign rem_sh   = {rem_q, a_q[31]};
  assign rem_diff = rem_sh - {1'b0, b_q};
  assign q_next   = {a_q[30:0], ~rem_diff[32]};
  assign r_next   = rem_diff[32] ? rem_sh[31:0] : rem_diff[31:0];

  assign op_signed = ~req_op[0];

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    a_d     = a_q;
    b_d     = b_q;
    rem_d   = rem_q;
    sgn_d   = sgn_q;
    qneg_d  = qneg_q;
    rneg_d  = rneg_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    rv_d    = 1'b0;
    we_d    = 1'b0;
    if (flush) begin
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (req_valid) begin
            sgn_d = op_signed;
            cnt_d = '0;
            if (!req_op[1]) begin
              a_d     = req_a;
              b_d     = req_b;
              state_d = S_MUL;
            end else if (req_b == 32'd0) begin
              hi_d    = req_a;
              lo_d    = '1;
              rv_d    = 1'b1;
              state_d = S_DONE;
            end else begin
              a_d     = (op_signed && req_a[31]) ? -req_a : req_a;
              b_d     = (op_signed && req_b[31]) ? -req_b : req_b;
              rem_d   = '0;
              qneg_d  = op_signed & (req_a[31] ^ req_b[31]);
              rneg_d  = op_signed & req_a[31];
              state_d = S_DIV;
            end
          end
        end
        S_MUL: begin
          if (cnt_q == 32'(MUL_LATENCY - 1)) begin
            hi_d    = prod[63:32];
            lo_d    = prod[31:0];
            rv_d    = 1'b1;
            we_d    = 1'b1;
            state_d = S_DONE;
          end else begin
            cnt_d = cnt_q + 32'd1;
          end
        end
        S_DIV: begin
          a_d   = q_next;
          rem_d = r_next;
          if (cnt_q == 32'd31) begin
            lo_d    = qneg_q ? -q_next : q_next;
            hi_d    = rneg_q ? -r_next : r_next;
            rv_d    = 1'b1;
            we_d    = 1'b1;
            state_d = S_DONE;
          end else begin
            cnt_d = cnt_q + 32'd1;
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      rem_q   <= '0;
      sgn_q   <= 1'b0;
      qneg_q  <= 1'b0;
      rneg_q  <= 1'b0;
      hi_q    <= '0;
      lo_q    <= '0;
      rv_q    <= 1'b0;
      we_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      a_q     <= a_d;
      b_q     <= b_d;
      rem_q   <= rem_d;
      sgn_q   <= sgn_d;
      qneg_q  <= qneg_d;
      rneg_q  <= rneg_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      rv_q    <= rv_d;
      we_q    <= we_d;
    end
  end

  assign busy      = (state_q != S_IDLE);
  assign req_ready = (state_q == S_IDLE);
  assign stall     = busy | (mf_req & busy);
  assign res_valid = rv_q & ~flush;
  assign whi       = we_q & ~flush;
  assign wlo       = we_q & ~flush;
  assign wHiData   = hi_q;
  assign wLoData   = lo_q;

endmodule

// File: tb/tb_hilo_mdu_seq.sv
// tb/tb_hilo_mdu_seq.sv - randomized self-checking bench for hilo_mdu_seq against an arithmetic model
module tb_hilo_mdu_seq;
  localparam int unsigned L = 2;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        req_valid = 1'b0;
  logic [1:0]  req_op = 2'b00;
  logic [31:0] req_a = '0;
  logic [31:0] req_b = '0;
  logic        req_ready;
  logic        flush = 1'b0;
  logic        mf_req = 1'b0;
  logic        stall, busy, res_valid, whi, wlo;
  logic [31:0] wHiData, wLoData;

  int n_tests = 0;
  int n_fail  = 0;

  hilo_mdu_seq #(.MUL_LATENCY(L)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_op(req_op),
    .req_a(req_a), .req_b(req_b), .req_ready(req_ready), .flush(flush),
    .mf_req(mf_req), .stall(stall), .busy(busy), .res_valid(res_valid),
    .wHiData(wHiData), .wLoData(wLoData), .whi(whi), .wlo(wlo)
  );

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Expected results straight from the arithmetic definitions of the four ops.
  task automatic model(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                       output logic [31:0] hi, output logic [31:0] lo,
                       output logic we, output int lat);
    longint      sa, sb, q, r;
    logic [63:0] p;
    we = 1'b1;
    case (op)
      2'b00: begin
        p = longint'($signed(a)) * longint'($signed(b));
        hi = p[63:32]; lo = p[31:0]; lat = L + 1;
      end
      2'b01: begin
        p = {32'd0, a} * {32'd0, b};
        hi = p[63:32]; lo = p[31:0]; lat = L + 1;
      end
      default: begin
        if (b == 32'd0) begin
          hi = a; lo = 32'hFFFF_FFFF; we = 1'b0; lat = 1;
        end else if (op == 2'b10) begin
          sa = longint'($signed(a)); sb = longint'($signed(b));
          q = sa / sb; r = sa % sb;
          lo = q[31:0]; hi = r[31:0]; lat = 33;
        end else begin
          lo = a / b; hi = a % b; lat = 33;
        end
      end
    endcase
  endtask

  task automatic start_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    @(negedge clk);
    req_valid = 1'b1; req_op = op; req_a = a; req_b = b;
    @(posedge clk);
    #1 req_valid = 1'b0;
  endtask

  task automatic run_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b, input logic mf);
    logic [31:0] ehi, elo, ghi, glo;
    logic        ewe, gwhi, gwlo;
    int          lat, seen, vcyc, bad;
    model(op, a, b, ehi, elo, ewe, lat);
    @(negedge clk);
    mf_req = 1'b1;
    #1;
    check_eq("idle_ready", {63'd0, req_ready}, 64'd1);
    check_eq("idle_mf_no_stall", {63'd0, stall}, 64'd0);
    mf_req = mf;
    start_op(op, a, b);
    seen = 0; vcyc = 0; bad = 0; ghi = '0; glo = '0; gwhi = 1'b0; gwlo = 1'b0;
    for (int c = 1; c <= lat + 1; c++) begin
      @(negedge clk);
      if (c <= lat && (!busy || !stall || req_ready)) bad++;
      if (res_valid) begin
        seen++; vcyc = c; ghi = wHiData; glo = wLoData; gwhi = whi; gwlo = wlo;
      end
    end
    check_eq("busy_window", 64'(bad), 64'd0);
    check_eq("valid_count", 64'(seen), 64'd1);
    check_eq("valid_cycle", 64'(vcyc), 64'(lat));
    check_eq("hi", {32'd0, ghi}, {32'd0, ehi});
    check_eq("lo", {32'd0, glo}, {32'd0, elo});
    check_eq("whi", {63'd0, gwhi}, {63'd0, ewe});
    check_eq("wlo", {63'd0, gwlo}, {63'd0, ewe});
    check_eq("end_busy", {63'd0, busy}, 64'd0);
    check_eq("end_stall", {63'd0, stall}, 64'd0);
    mf_req = 1'b0;
  endtask

  initial begin
    int pulses, v2cyc;
    logic [31:0] lo2;
    logic [1:0]  rop;
    logic [31:0] ra, rb;

    #3;
    check_eq("rst_busy", {63'd0, busy}, 64'd0);
    check_eq("rst_ready", {63'd0, req_ready}, 64'd1);
    check_eq("rst_valid", {63'd0, res_valid}, 64'd0);
    check_eq("rst_data", {wHiData, wLoData}, 64'd0);
    repeat (2) @(negedge clk);
    rst = 1'b1;

    run_op(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
    run_op(2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1);
    run_op(2'b00, 32'h7FFF_FFFF, 32'd2, 1'b0);
    run_op(2'b10, -32'sd7, 32'd2, 1'b1);
    run_op(2'b11, 32'd100, 32'd7, 1'b0);
    run_op(2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
    run_op(2'b11, 32'd5, 32'd0, 1'b1);
    run_op(2'b10, 32'h8000_0000, 32'd0, 1'b0);

    // flush mid-divide, then a fresh multiply
    start_op(2'b10, 32'd1000, 32'd3);
    pulses = 0;
    for (int c = 1; c <= 10; c++) begin
      @(negedge clk);
      if (res_valid) pulses++;
    end
    flush = 1'b1;
    @(posedge clk);
    #1 flush = 1'b0;
    @(negedge clk);
    check_eq("flush_div_no_valid", 64'(pulses), 64'd0);
    check_eq("flush_div_idle", {62'd0, busy, req_ready}, 64'd1);
    run_op(2'b01, 32'd3, 32'd4, 1'b0);

    // flush in the DONE cycle suppresses the write
    start_op(2'b01, 32'd7, 32'd9);
    repeat (L + 1) @(negedge clk);
    check_eq("done_valid_pre", {63'd0, res_valid}, 64'd1);
    flush = 1'b1;
    #1;
    check_eq("done_flush_gate", {61'd0, res_valid, whi, wlo}, 64'd0);
    @(posedge clk);
    #1 flush = 1'b0;
    @(negedge clk);
    check_eq("done_flush_idle", {63'd0, busy}, 64'd0);

    // flush wins over a request in IDLE
    @(negedge clk);
    req_valid = 1'b1; req_op = 2'b01; req_a = 32'd1; req_b = 32'd1; flush = 1'b1;
    @(posedge clk);
    #1 req_valid = 1'b0; flush = 1'b0;
    @(negedge clk);
    check_eq("flush_beats_req", {63'd0, busy}, 64'd0);

    // request held across a whole multiply is taken again only in IDLE
    @(negedge clk);
    req_valid = 1'b1; req_op = 2'b01; req_a = 32'd5; req_b = 32'd6;
    @(posedge clk);
    pulses = 0; v2cyc = 0; lo2 = '0;
    for (int c = 1; c <= 2 * L + 4; c++) begin
      @(negedge clk);
      if (res_valid) begin
        pulses++; v2cyc = c; lo2 = wLoData;
      end
      if (c == L + 2) begin
        check_eq("held_ready_idle", {63'd0, req_ready}, 64'd1);
        @(posedge clk);
        #1 req_valid = 1'b0;
      end
    end
    check_eq("held_pulses", 64'(pulses), 64'd2);
    check_eq("held_second_cycle", 64'(v2cyc), 64'(2 * L + 3));
    check_eq("held_lo", {32'd0, lo2}, 64'd30);

    // asynchronous reset in the middle of a divide
    start_op(2'b10, 32'h1234_5678, 32'd77);
    repeat (20) @(negedge clk);
    rst = 1'b0;
    #1;
    check_eq("mid_rst_flags", {59'd0, res_valid, whi, wlo, busy, stall}, 64'd0);
    check_eq("mid_rst_data", {wHiData, wLoData}, 64'd0);
    check_eq("mid_rst_ready", {63'd0, req_ready}, 64'd1);
    @(negedge clk);
    rst = 1'b1;
    pulses = 0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (res_valid || busy) pulses++;
    end
    check_eq("post_rst_quiet", 64'(pulses), 64'd0);
    check_eq("post_rst_ready", {63'd0, req_ready}, 64'd1);

    for (int i = 0; i < 40; i++) begin
      rop = 2'($urandom_range(0, 3));
      ra  = $urandom;
      rb  = $urandom;
      case ($urandom_range(0, 5))
        0: rb = 32'd0;
        1: rb = 32'($urandom_range(1, 16));
        2: ra = 32'($urandom_range(0, 255));
        3: rb = -32'($urandom_range(1, 16));
        default: ;
      endcase
      run_op(rop, ra, rb, 1'($urandom_range(0, 1)));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
